// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: x/y counters, sync pulses, data-enable, sof/eol strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          sof,
  output logic          eol
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,output logic [15:0]  frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  // Window bounds carry one extra bit so an end bound equal to the total still fits.
  localparam logic [CW:0] H_ACT_E = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END  = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_E = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG  = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END  = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic H_ON = (H_POL != 0);
  localparam logic V_ON = (V_POL != 0);

  logic [CW-1:0] r_x, r_y;
  logic          r_hs, r_vs, r_de, r_sof, r_eol;
  logic [CW-1:0] w_nx, w_ny;
  logic [CW:0]   w_nxe, w_nye;
  logic          w_x_last, w_y_last;

  always_comb begin
    w_x_last = (r_x == H_LAST);
    w_y_last = (r_y == V_LAST);
    w_nx     = w_x_last ? '0 : r_x + 1'b1;
    w_ny     = r_y;
    if (w_x_last) w_ny = w_y_last ? '0 : r_y + 1'b1;
    w_nxe    = {1'b0, w_nx};
    w_nye    = {1'b0, w_ny};
  end

  // All flags are derived from the next coordinates so they stay aligned with x/y.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= H_LAST;
      r_y   <= V_LAST;
      r_hs  <= ~H_ON;
      r_vs  <= ~V_ON;
      r_de  <= 1'b0;
      r_sof <= 1'b0;
      r_eol <= 1'b0;
    end else if (pix_ce) begin
      r_x   <= w_nx;
      r_y   <= w_ny;
      r_hs  <= (w_nxe >= HS_BEG && w_nxe < HS_END) ? H_ON : ~H_ON;
      r_vs  <= (w_nye >= VS_BEG && w_nye < VS_END) ? V_ON : ~V_ON;
      r_de  <= (w_nxe < H_ACT_E) && (w_nye < V_ACT_E);
      r_sof <= (w_nx == '0) && (w_ny == '0);
      r_eol <= (w_nx == H_LAST);
    end else begin
      r_sof <= 1'b0;
      r_eol <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_fcnt;
  always_ff @(posedge clk) begin
    if (rst)                                        r_fcnt <= '0;
    else if (pix_ce && w_nx == '0 && w_ny == '0)    r_fcnt <= r_fcnt + 16'd1;
  end
  assign frame_cnt = r_fcnt;
`endif

  assign x     = r_x;
  assign y     = r_y;
  assign hsync = r_hs;
  assign vsync = r_vs;
  assign de    = r_de;
  assign sof   = r_sof;
  assign eol   = r_eol;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen in a 16x8 raster (H_POL=1, V_POL=0).
module tb_vga_timing_gen;
  localparam int CW = 11;

  logic clk = 1'b0, rst = 1'b0, pix_ce = 1'b0;
  logic [CW-1:0] x, y;
  logic hsync, vsync, de, sof, eol;
  logic [15:0] frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1), .V_POL(0), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync), .de(de), .sof(sof), .eol(eol)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,.frame_cnt(frame_cnt)
`endif
  );

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign frame_cnt = 16'd0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    int x; int y; int hs; int vs; int de; int sof; int eol; int fc;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int cyc = 0, sof_cnt = 0, last_sof = -1, prev_sof = -1;
  logic prev_sof_v = 1'b0, prev_eol_v = 1'b0;

  // Reference raster as a linear pixel index 0..127.
  int p = 127, m_fc = 0;

  task automatic step(input logic r, input logic ce);
    exp_t e;
    int s, l;
    @(negedge clk);
    rst = r; pix_ce = ce;
    s = 0; l = 0;
    if (r) begin
      p = 127; m_fc = 0;
    end else if (ce) begin
      p = (p + 1) % 128;
      s = (p == 0);
      l = (p % 16 == 15);
      if (s != 0) m_fc = (m_fc + 1) % 65536;
    end
    e.x = p % 16; e.y = p / 16;
    e.de  = (e.x < 8 && e.y < 4) ? 1 : 0;
    e.hs  = (e.x >= 10 && e.x <= 12) ? 1 : 0;
    e.vs  = (e.y == 5 || e.y == 6) ? 0 : 1;
    e.sof = s; e.eol = l;
`ifdef VGA_TIMING_FRAME_CNT_EN
    e.fc = m_fc;
`else
    e.fc = 0;
`endif
    q.push_back(e);
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a.x = int'(x); a.y = int'(y); a.hs = int'(hsync); a.vs = int'(vsync);
      a.de = int'(de); a.sof = int'(sof); a.eol = int'(eol); a.fc = int'(frame_cnt);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL pixel@%0d: got x=%0d y=%0d hs=%0d vs=%0d de=%0d sof=%0d eol=%0d fc=%0d expected x=%0d y=%0d hs=%0d vs=%0d de=%0d sof=%0d eol=%0d fc=%0d",
                 cyc, a.x, a.y, a.hs, a.vs, a.de, a.sof, a.eol, a.fc,
                 e.x, e.y, e.hs, e.vs, e.de, e.sof, e.eol, e.fc);
      end
      checks++;
      if ((sof === 1'b1 && prev_sof_v) || (eol === 1'b1 && prev_eol_v)) begin
        errors++;
        $display("FAIL strobe_width@%0d: got sof=%0b eol=%0b twice in a row, expected single-cycle", cyc, sof, eol);
      end
      prev_sof_v = (sof === 1'b1);
      prev_eol_v = (eol === 1'b1);
      if (sof === 1'b1) begin
        sof_cnt++;
        prev_sof = last_sof;
        last_sof = cyc;
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    // 1. reset parks on last blanking pixel; first enabled edge presents (0,0)
    step(1, 1); step(1, 0); drain();
    chk("rst_x", int'(x), 15); chk("rst_y", int'(y), 7);
    chk("rst_de", int'(de), 0); chk("rst_hs", int'(hsync), 0); chk("rst_vs", int'(vsync), 1);
    chk("rst_sof", int'(sof), 0); chk("rst_fc", int'(frame_cnt), 0);
    step(0, 1); drain();
    chk("first_x", int'(x), 0); chk("first_y", int'(y), 0);
    chk("first_de", int'(de), 1); chk("first_sof", int'(sof), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("first_fc", int'(frame_cnt), 1);
`endif
    // 2/3. line and frame sweep
    repeat (127) step(0, 1);
    drain();
    s0 = sof_cnt;
    repeat (128) step(0, 1);
    drain();
    chk("sof_per_frame", sof_cnt - s0, 1);
    // 4. clock-enable gaps, then half-rate pixel clock
    step(0, 1); step(0, 0); step(0, 0); step(0, 1);
    repeat (300) begin step(0, 1); step(0, 0); end
    drain();
    chk("half_rate_frame_clk", last_sof - prev_sof, 256);
    // 5. mid-frame reset while at (9,5) with pix_ce low
    step(1, 0);
    repeat (90) step(0, 1);
    step(0, 0); drain();
    chk("mid_x", int'(x), 9); chk("mid_y", int'(y), 5);
    chk("mid_vs", int'(vsync), 0); chk("mid_hs", int'(hsync), 0); chk("mid_de", int'(de), 0);
    step(1, 0); drain();
    chk("mrst_x", int'(x), 15); chk("mrst_y", int'(y), 7);
    chk("mrst_de", int'(de), 0); chk("mrst_hs", int'(hsync), 0); chk("mrst_vs", int'(vsync), 1);
    step(0, 0); step(0, 1); drain();
    chk("mrst_sof", int'(sof), 1); chk("mrst_x0", int'(x), 0); chk("mrst_y0", int'(y), 0);
    // 6. two more full frames
    repeat (256) step(0, 1);
    drain();
    chk("frames_x", int'(x), 0); chk("frames_y", int'(y), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frames_fc", int'(frame_cnt), 3);
`endif
    step(0, 0); drain();
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator, the successor to the fixed 800x600@60 generator. All horizontal and vertical timing fields are parameters, and sync polarity is selectable. Adds a pixel clock-enable, a data-enable (de) output, and start-of-frame / end-of-line strobes, so one block drives any VGA/SVGA mode from a single system clock. It sits between the clock source and the pixel/pattern generators, which consume x, y and de.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync pulse width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync pulse width (lines)
V_BP, 23, vertical back porch (lines)
H_POL, 1, 1 = hsync active-high, 0 = active-low
V_POL, 1, 1 = vsync active-high, 0 = active-low
CW, 11, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pix_ce  in  1  pixel clock-enable; timing advances only on cycles with pix_ce=1
x  out  CW  current column, 0..H_TOTAL-1
y  out  CW  current row, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity per H_POL
vsync  out  1  vertical sync, polarity per V_POL
de  out  1  1 when x<H_ACTIVE and y<V_ACTIVE
sof  out  1  one-cycle strobe, high while (x,y)=(0,0) is first presented
eol  out  1  one-cycle strobe, high while x=H_TOTAL-1 is first presented

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- All outputs are registered and mutually aligned: hsync, vsync, de, sof and eol describe the pixel currently on x/y.
- Reset (rst=1 at a clk edge) overrides pix_ce. Values after reset: x=H_TOTAL-1, y=V_TOTAL-1, de=0, hsync=!H_POL, vsync=!V_POL, sof=0, eol=0. The raster parks on the last blanking pixel, so the first pix_ce after reset presents (0,0).
- Each clk edge with rst=0 and pix_ce=1:
  - If x<H_TOTAL-1: x<=x+1, y unchanged.
  - If x==H_TOTAL-1: x<=0. Then y<=y+1, or y<=0 if y==V_TOTAL-1.
- pix_ce=0: x, y, hsync, vsync and de hold their values. sof and eol go to 0, so each strobe lasts exactly one clk.
- Horizontal sync is active when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC. Vertical sync is active when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. Both windows are half-open intervals.
- vsync changes on the same edge that y changes, i.e. aligned to x=0.
- sof=1 for the single clk on which the registers are loaded with (0,0). eol=1 for the single clk on which x is loaded with H_TOTAL-1.
- Counters never exceed H_TOTAL-1 or V_TOTAL-1. Wrap to 0 is exact, with no extra column or row.
- Reset mid-frame: the next edge applies the reset values regardless of counter state or pix_ce.
- There is no ready/valid handshake. Downstream blocks sample on pix_ce-qualified cycles.

Optional Feature:
Macro VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output port frame_cnt (16 bits, unsigned).
  - Reset value 0.
  - Increments by 1 on every edge that sets sof=1; wraps from 65535 to 0.
  - The first frame after reset therefore reports frame_cnt=1 while at (0,0).
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
Use small mode H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); H_POL=1, V_POL=0; pix_ce=1 unless stated.
1. Reset and first pixel: assert rst for 2 clk, then release. Expect x=15, y=7, de=0, hsync=0, vsync=1. Next edge: x=0, y=0, de=1, sof=1.
2. Horizontal timing: sweep one line. de=1 only for x=0..7; hsync=1 only for x=10..12; eol=1 only at x=15. At x=15→0, y increments.
3. Vertical and frame wrap: run a full frame (128 pixels). vsync=0 only for y=5..6; de=0 for all y>=4. Wrap (15,7)→(0,0) with sof=1 exactly once per 128 enabled cycles.
4. Clock-enable: toggle pix_ce 1,0,0,1. x advances only on enabled edges. sof/eol never last longer than 1 clk. With pix_ce=1 every other clk, a frame takes 256 clk.
5. Mid-frame reset: at (9,5) with pix_ce=0, assert rst for 1 clk. Registers show (15,7), de=0, hsync=0, vsync=1. The next enabled edge gives (0,0) with sof=1.
6. With VGA_TIMING_FRAME_CNT_EN defined: frame_cnt=0 after reset, 1 at the first sof, and 3 after two further full frames.
